// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall/flush control and saturating
// bubble and stall event counters.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 8,
  parameter int RA_W   = 5,
  parameter int WB_W   = 2,
  parameter int M_W    = 3,
  parameter int EX_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [WB_W-1:0]   wb,
  input  logic [M_W-1:0]    m,
  input  logic [EX_W-1:0]   ex,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] instruction,
  input  logic [DATA_W-1:0] reg1,
  input  logic [DATA_W-1:0] reg2,
  input  logic [DATA_W-1:0] sign_extend,
  input  logic [RA_W-1:0]   rt,
  input  logic [RA_W-1:0]   rd,
  input  logic              cnt_clr,
  output logic              out_valid,
  output logic [WB_W-1:0]   _wb,
  output logic [M_W-1:0]    _m,
  output logic [EX_W-1:0]   _ex,
  output logic [PC_W-1:0]   _pc,
  output logic [DATA_W-1:0] _instruction,
  output logic [DATA_W-1:0] _reg1,
  output logic [DATA_W-1:0] _reg2,
  output logic [DATA_W-1:0] _sign_extend,
  output logic [RA_W-1:0]   _rt,
  output logic [RA_W-1:0]   _rd,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [EX_W-1:0]   ex;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] instruction;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [DATA_W-1:0] sign_extend;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   rd;
  } stage_t;

  stage_t           stage_in, stage_d, stage_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic             bubble_ev, stall_ev;

  always_comb begin
    stage_in = '{wb: wb, m: m, ex: ex, pc: pc, instruction: instruction,
                 reg1: reg1, reg2: reg2, sign_extend: sign_extend,
                 rt: rt, rd: rd};
    stage_d   = stage_q;
    valid_d   = valid_q;
    bubble_ev = 1'b0;
    stall_ev  = 1'b0;
    if (flush) begin
      stage_d   = '0;
      valid_d   = 1'b0;
      bubble_ev = 1'b1;
    end else if (stall) begin
      stall_ev  = 1'b1;
    end else if (in_valid) begin
      stage_d   = stage_in;
      valid_d   = 1'b1;
    end else begin
      // Bubble keeps data but kills control so it cannot write RF/memory.
      stage_d    = stage_in;
      stage_d.wb = '0;
      stage_d.m  = '0;
      stage_d.ex = '0;
      valid_d    = 1'b0;
      bubble_ev  = 1'b1;
    end

    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (cnt_clr) begin
      bubble_cnt_d = '0;
      stall_cnt_d  = '0;
    end else begin
      if (bubble_ev && !(&bubble_cnt_q)) bubble_cnt_d = bubble_cnt_q + 1'b1;
      if (stall_ev  && !(&stall_cnt_q))  stall_cnt_d  = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q      <= '0;
      valid_q      <= 1'b0;
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      stage_q      <= stage_d;
      valid_q      <= valid_d;
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_valid    = valid_q;
  assign _wb          = stage_q.wb;
  assign _m           = stage_q.m;
  assign _ex          = stage_q.ex;
  assign _pc          = stage_q.pc;
  assign _instruction = stage_q.instruction;
  assign _reg1        = stage_q.reg1;
  assign _reg2        = stage_q.reg2;
  assign _sign_extend = stage_q.sign_extend;
  assign _rt          = stage_q.rt;
  assign _rd          = stage_q.rd;
  assign bubble_cnt   = bubble_cnt_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed plus randomized bench for id_ex_stage_reg against a
// cycle-level behavioural model of the stage register.
module tb_id_ex_stage_reg;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, in_valid, cnt_clr;
  logic [1:0]  wb;
  logic [2:0]  m;
  logic [3:0]  ex;
  logic [7:0]  pc;
  logic [31:0] instruction, reg1, reg2, sign_extend;
  logic [4:0]  rt, rd;

  logic        out_valid;
  logic [1:0]  q_wb;
  logic [2:0]  q_m;
  logic [3:0]  q_ex;
  logic [7:0]  q_pc;
  logic [31:0] q_ins, q_r1, q_r2, q_se;
  logic [4:0]  q_rt, q_rd;
  logic [CNT_W-1:0] bubble_cnt, stall_cnt;

  id_ex_stage_reg #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .wb(wb), .m(m), .ex(ex), .pc(pc), .instruction(instruction),
    .reg1(reg1), .reg2(reg2), .sign_extend(sign_extend), .rt(rt), .rd(rd),
    .cnt_clr(cnt_clr), .out_valid(out_valid),
    ._wb(q_wb), ._m(q_m), ._ex(q_ex), ._pc(q_pc), ._instruction(q_ins),
    ._reg1(q_r1), ._reg2(q_r2), ._sign_extend(q_se), ._rt(q_rt), ._rd(q_rd),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model state
  logic        e_valid;
  logic [1:0]  e_wb;
  logic [2:0]  e_m;
  logic [3:0]  e_ex;
  logic [7:0]  e_pc;
  logic [31:0] e_ins, e_r1, e_r2, e_se;
  logic [4:0]  e_rt, e_rd;
  int          e_bc, e_sc;

  function automatic int sat_add(int v, int inc);
    return (v + inc > CMAX) ? CMAX : v + inc;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 128'(out_valid), 128'(e_valid));
    chk({tag, ".ctrl"}, 128'({q_wb, q_m, q_ex}), 128'({e_wb, e_m, e_ex}));
    chk({tag, ".pc"}, 128'(q_pc), 128'(e_pc));
    chk({tag, ".data"}, {q_ins, q_r1, q_r2, q_se}, {e_ins, e_r1, e_r2, e_se});
    chk({tag, ".ra"}, 128'({q_rt, q_rd}), 128'({e_rt, e_rd}));
    chk({tag, ".bcnt"}, 128'(bubble_cnt), 128'(e_bc));
    chk({tag, ".scnt"}, 128'(stall_cnt), 128'(e_sc));
  endtask

  // Apply current inputs for one edge, advance the model, compare.
  task automatic step(input string tag);
    bit bub, stl;
    if (rst) begin
      {e_valid, e_wb, e_m, e_ex, e_pc, e_ins, e_r1, e_r2, e_se, e_rt, e_rd} = '0;
      e_bc = 0; e_sc = 0;
    end else begin
      bub = flush || (!stall && !in_valid);
      stl = !flush && stall;
      if (flush) begin
        {e_valid, e_wb, e_m, e_ex, e_pc, e_ins, e_r1, e_r2, e_se, e_rt, e_rd} = '0;
      end else if (!stall) begin
        e_valid = in_valid;
        e_wb = in_valid ? wb : 2'd0;
        e_m  = in_valid ? m  : 3'd0;
        e_ex = in_valid ? ex : 4'd0;
        e_pc = pc; e_ins = instruction; e_r1 = reg1; e_r2 = reg2;
        e_se = sign_extend; e_rt = rt; e_rd = rd;
      end
      if (cnt_clr) begin
        e_bc = 0; e_sc = 0;
      end else begin
        e_bc = sat_add(e_bc, int'(bub));
        e_sc = sat_add(e_sc, int'(stl));
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic rand_data();
    wb = 2'($urandom); m = 3'($urandom); ex = 4'($urandom); pc = 8'($urandom);
    instruction = $urandom; reg1 = $urandom; reg2 = $urandom;
    sign_extend = $urandom; rt = 5'($urandom); rd = 5'($urandom);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b1; cnt_clr = 1'b0;
    rand_data();
    @(negedge clk);
    step("reset");
    rst = 1'b0;

    // Reset then load
    rand_data(); in_valid = 1'b1; pc = 8'h04; reg1 = 32'hAA; wb = 2'b11;
    step("load");
    chk("load.pc_const", 128'(q_pc), 128'h04);
    chk("load.reg1_const", 128'(q_r1), 128'hAA);
    chk("load.wb_const", 128'(q_wb), 128'h3);
    chk("load.cnt_zero", 128'({bubble_cnt, stall_cnt}), 128'h0);

    // Stall hold for 3 cycles while inputs move on
    rand_data(); pc = 8'h10; step("pre_stall");
    stall = 1'b1; rand_data(); pc = 8'h14;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall.pc_hold", 128'(q_pc), 128'h10);
    end
    chk("stall.cnt3", 128'(stall_cnt), 128'd3);
    stall = 1'b0;
    step("release");
    chk("release.pc", 128'(q_pc), 128'h14);

    // Flush beats stall on a held valid instruction
    stall = 1'b1; step("hold");
    flush = 1'b1; step("flush_stall");
    chk("flush.valid", 128'(out_valid), 128'd0);
    chk("flush.bcnt1", 128'(bubble_cnt), 128'd1);
    chk("flush.scnt4", 128'(stall_cnt), 128'd4);
    flush = 1'b0; stall = 1'b0;

    // Invalid input inserts a bubble with killed control
    rand_data(); in_valid = 1'b0; m = 3'b111; rd = 5'd9;
    step("bubble");
    chk("bubble.m", 128'(q_m), 128'd0);
    chk("bubble.rd", 128'(q_rd), 128'd9);
    chk("bubble.bcnt2", 128'(bubble_cnt), 128'd2);
    in_valid = 1'b1;

    // Saturation then clear-with-stall
    stall = 1'b1;
    for (int i = 0; i < 20; i++) begin rand_data(); step("sat"); end
    chk("sat.scnt_max", 128'(stall_cnt), 128'(CMAX));
    cnt_clr = 1'b1; step("clr");
    chk("clr.scnt0", 128'(stall_cnt), 128'd0);
    cnt_clr = 1'b0; stall = 1'b0;

    // Reset mid-stall
    rand_data(); pc = 8'h20; step("pre_rst");
    stall = 1'b1; rand_data(); step("rst_hold");
    rst = 1'b1; flush = 1'b1; cnt_clr = 1'b1; step("mid_rst");
    chk("mid_rst.pc0", 128'(q_pc), 128'd0);
    rst = 1'b0; flush = 1'b0; cnt_clr = 1'b0; stall = 1'b0;
    rand_data(); in_valid = 1'b1; pc = 8'h24; step("post_rst");
    chk("post_rst.pc", 128'(q_pc), 128'h24);
    chk("post_rst.valid", 128'(out_valid), 128'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_data();
      rst      = ($urandom_range(49) == 0);
      flush    = ($urandom_range(7) == 0);
      stall    = ($urandom_range(3) == 0);
      cnt_clr  = ($urandom_range(19) == 0);
      in_valid = ($urandom_range(3) != 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/id_ex_stage_reg.md
ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: DATA_W, 32, operand/instruction width; PC_W, 8, PC width; RA_W, 5, register-address width; WB_W, 2, WB control width; M_W, 3, MEM control width; EX_W, 4, EX control width; CNT_W, 16, event-counter width.
REQ-002 Ports (name, direction, width, meaning) SHALL be: clk, in, 1, sole clock, all state on rising edge.
REQ-003 rst, in, 1, reset, synchronous, active-high.
REQ-004 stall, in, 1, hold current contents (hazard unit).
REQ-005 flush, in, 1, replace the next stage contents with a bubble (branch/exception).
REQ-006 in_valid, in, 1, the ID stage is presenting a real instruction.
REQ-007 wb, m, ex, in, WB_W/M_W/EX_W, decoded control fields.
REQ-008 pc, in, PC_W; instruction, reg1, reg2, sign_extend, in, DATA_W each; rt, rd, in, RA_W each.
REQ-009 cnt_clr, in, 1, clear both event counters.
REQ-010 out_valid, out, 1, the EX stage holds a real instruction.
REQ-011 _wb, _m, _ex, _pc, _instruction, _reg1, _reg2, _sign_extend, _rt, _rd, out, widths matching their inputs, registered copies.
REQ-012 bubble_cnt, out, CNT_W, bubbles inserted; stall_cnt, out, CNT_W, cycles held.

Function
REQ-013 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-014 Update priority on each rising edge SHALL be rst, then flush, then stall, then load.
REQ-015 Load (rst=0, flush=0, stall=0, in_valid=1): every output field SHALL take its input value one cycle later, and out_valid SHALL become 1.
REQ-016 Load with in_valid=0: the block SHALL insert a bubble; out_valid, _wb, _m and _ex SHALL become 0; data fields SHALL load their inputs; bubble_cnt SHALL increment.
REQ-017 Flush (flush=1): out_valid, _wb, _m, _ex, _pc, _instruction, _reg1, _reg2, _sign_extend, _rt and _rd SHALL all become 0; bubble_cnt SHALL increment.
REQ-018 Flush SHALL override stall and in_valid in the same cycle, and stall_cnt SHALL not increment in that cycle.
REQ-019 Stall (stall=1, flush=0): every output field and out_valid SHALL hold its value; stall_cnt SHALL increment.
REQ-020 A stall that lasts N consecutive cycles SHALL add N to stall_cnt and SHALL leave the held contents bit-identical throughout.
REQ-021 Counters SHALL saturate at all-ones with no wrap-around.
REQ-022 cnt_clr=1 SHALL zero both counters on the next edge; an event in the same cycle SHALL be discarded, because clear wins.
REQ-023 cnt_clr SHALL not affect the pipeline fields.
REQ-024 Control fields of any bubble SHALL be 0 so that a bubble can never write the register file or memory.

Reset
REQ-025 rst=1 at a rising edge SHALL set every output, including out_valid and both counters, to 0, overriding flush, stall and cnt_clr.
REQ-026 A reset asserted mid-stall SHALL discard the held instruction; the first edge after rst deasserts SHALL perform a normal load/stall/flush decision.
REQ-027 Power-up contents before the first reset SHALL be treated as undefined by the verification environment.

Verification
REQ-028 Reset then load: rst 1 cycle, then in_valid=1, pc=8'h04, reg1=32'h0000_00AA, wb=2'b11 -> the next cycle shows out_valid=1, _pc=8'h04, _reg1=32'hAA, _wb=2'b11; counters remain 0.
REQ-029 Stall hold: load pc=8'h10, then stall=1 for 3 cycles while the inputs change to pc=8'h14 -> _pc stays 8'h10 for 3 cycles with stall_cnt=3; after release, _pc=8'h14.
REQ-030 Flush beats stall: a valid instruction is held with stall=1 and flush=1 in the same cycle -> all fields and out_valid are 0, bubble_cnt=1, stall_cnt unchanged.
REQ-031 Invalid input: in_valid=0, m=3'b111, rd=5'd9 -> _m=0, out_valid=0, _rd=5'd9, bubble_cnt increments by 1.
REQ-032 Saturation/clear: with CNT_W=4, 20 stall cycles -> stall_cnt=4'hF; then cnt_clr together with stall=1 -> stall_cnt=0 on the next edge.
REQ-033 Reset mid-stall: stall=1 holding pc=8'h20, rst=1 for 1 cycle -> all outputs are 0; the next edge with in_valid=1 and pc=8'h24 -> _pc=8'h24, out_valid=1.
